// File: rtl/oam_dma_if.sv
// Signal bundle between the OAM DMA controller and the CPU register, source bus and OAM.
// The controller takes the master side; the CPU/memory environment takes the slave side.
interface oam_dma_if;
  logic        m_tick;
  logic        start;
  logic [7:0]  start_page;
  logic [7:0]  dma_reg;
  logic [15:0] src_addr;
  logic        src_re;
  logic [7:0]  src_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        busy;
  logic        cpu_block;

  modport master (
    input  m_tick, start, start_page, src_rdata,
    output dma_reg, src_addr, src_re, oam_addr, oam_wdata, oam_we, busy, cpu_block
  );

  modport slave (
    output m_tick, start, start_page, src_rdata,
    input  dma_reg, src_addr, src_re, oam_addr, oam_wdata, oam_we, busy, cpu_block
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies OAM_BYTES bytes from {page,8'h00} into OAM, one byte per
// machine cycle, after a one-machine-cycle start delay.
module oam_dma_ctrl #(
  parameter int unsigned OAM_BYTES = 160
) (
  input logic       clk,
  input logic       rst_n,
  oam_dma_if.master dma
);

  typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_e;

  localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;   // doubles as the CPU-visible DMA register
  logic [7:0] eff_page;
  logic       src_re;
  logic       oam_we;
  logic       busy;

  // Pages E0-FF are echo RAM; fetch from the mirrored C0-DF page instead.
  assign eff_page = (page_q[7:5] == 3'b111) ? page_q - 8'h20 : page_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      page_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    src_re  = 1'b0;
    oam_we  = 1'b0;

    unique case (state_q)
      IDLE:  ;
      DELAY: if (dma.m_tick) state_d = READ;
      READ: begin
        if (dma.m_tick) begin
          src_re  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        oam_we  = 1'b1;
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == LAST_IDX) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase

    // A start restarts from any state; a write in flight this clk is left intact,
    // but a fresh read is dropped since its byte would never be written.
    if (dma.start) begin
      page_d  = dma.start_page;
      idx_d   = '0;
      state_d = DELAY;
      src_re  = 1'b0;
    end
  end

  assign busy          = (state_q != IDLE);
  assign dma.busy      = busy;
  assign dma.cpu_block = busy;
  assign dma.dma_reg   = page_q;
  assign dma.src_re    = src_re;
  assign dma.src_addr  = src_re ? {eff_page, idx_q} : 16'h0000;
  assign dma.oam_we    = oam_we;
  assign dma.oam_addr  = oam_we ? idx_q : 8'h00;
  assign dma.oam_wdata = oam_we ? dma.src_rdata : 8'h00;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed-plus-random bench for oam_dma_ctrl: a 160-byte instance and a 4-byte instance,
// checked against a transaction-level model of the expected reads and OAM writes.
module tb_oam_dma_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  oam_dma_if bus_a();
  oam_dma_if bus_b();

  oam_dma_ctrl #(.OAM_BYTES(160)) dut_a (.clk(clk), .rst_n(rst_n), .dma(bus_a));
  oam_dma_ctrl #(.OAM_BYTES(4))   dut_b (.clk(clk), .rst_n(rst_n), .dma(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  logic       sel = 1'b0;      // 0: observe/drive dut_a, 1: dut_b
  int         tick_period = 4; // 0 selects random 2..5 clk spacing
  logic [7:0] key = 8'h00;     // source byte = low address byte ^ key

  // Selected-DUT view
  logic        s_start, s_src_re, s_oam_we, s_busy, s_cpu_block;
  logic [15:0] s_src_addr;
  logic [7:0]  s_oam_addr, s_oam_wdata, s_dma_reg;
  assign s_start     = sel ? bus_b.start     : bus_a.start;
  assign s_src_re    = sel ? bus_b.src_re    : bus_a.src_re;
  assign s_src_addr  = sel ? bus_b.src_addr  : bus_a.src_addr;
  assign s_oam_we    = sel ? bus_b.oam_we    : bus_a.oam_we;
  assign s_oam_addr  = sel ? bus_b.oam_addr  : bus_a.oam_addr;
  assign s_oam_wdata = sel ? bus_b.oam_wdata : bus_a.oam_wdata;
  assign s_busy      = sel ? bus_b.busy      : bus_a.busy;
  assign s_cpu_block = sel ? bus_b.cpu_block : bus_a.cpu_block;
  assign s_dma_reg   = sel ? bus_b.dma_reg   : bus_a.dma_reg;

  // Observed transactions
  logic [15:0] rd_q[$];
  int          rdt_q[$];
  logic [15:0] wr_q[$];
  int          tick_no = 0, start_tick = 0, busy_ticks = 0, overlap = 0;
  logic        pend = 1'b0;
  logic [7:0]  pend_data = 8'h00;

  // Expected transactions
  logic [15:0] exp_rd[$];
  int          exp_dt[$];
  logic [15:0] exp_wr[$];
  int          rd_base = 0, wr_base = 0, ov_base = 0;

  // Machine-cycle ticks and source memory returning data one clk after src_re.
  initial begin
    int gap;
    gap = 0;
    bus_a.m_tick = 1'b0; bus_b.m_tick = 1'b0;
    bus_a.src_rdata = 8'h00; bus_b.src_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (gap <= 0) begin
        bus_a.m_tick = 1'b1;
        gap = (tick_period == 0) ? int'($urandom_range(1, 4)) : tick_period - 1;
      end else begin
        bus_a.m_tick = 1'b0;
        gap = gap - 1;
      end
      bus_b.m_tick    = bus_a.m_tick;
      bus_a.src_rdata = pend ? pend_data : 8'($urandom);
      bus_b.src_rdata = bus_a.src_rdata;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.m_tick) tick_no++;
      if (s_start) begin
        start_tick = tick_no;
        busy_ticks = 0;
      end else if (bus_a.m_tick && s_busy) begin
        busy_ticks++;
      end
      if (s_src_re) begin
        rd_q.push_back(s_src_addr);
        rdt_q.push_back(tick_no - start_tick);
      end
      if (s_oam_we) wr_q.push_back({s_oam_addr, s_oam_wdata});
      if (s_src_re && s_oam_we) overlap++;
      pend      = s_src_re;
      pend_data = s_src_addr[7:0] ^ key;
    end else begin
      pend = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    rd_base = rd_q.size();
    wr_base = wr_q.size();
    ov_base = overlap;
    exp_rd.delete();
    exp_dt.delete();
    exp_wr.delete();
  endtask

  // Reference: byte i of a transfer reads eff_base+i on the (i+2)-th tick after start
  // and writes OAM[i] with that source byte.
  task automatic add_expected(input logic [7:0] page, input int count);
    int base;
    base = (page >= 8'hE0) ? (int'(page) - 32) * 256 : int'(page) * 256;
    for (int i = 0; i < count; i++) begin
      exp_rd.push_back(16'(base + i));
      exp_dt.push_back(i + 2);
      exp_wr.push_back({8'(i), 8'(i) ^ key});
    end
  endtask

  task automatic pulse_start(input logic [7:0] page);
    if (sel) begin bus_b.start = 1'b1; bus_b.start_page = page; end
    else     begin bus_a.start = 1'b1; bus_a.start_page = page; end
    @(posedge clk);
    #2;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic do_start(input logic coincide, input logic [7:0] page);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #2;
      guard++;
    end while ((bus_a.m_tick !== coincide) && guard < 20);
    check("start_slot", bus_a.m_tick, coincide);
    pulse_start(page);
  endtask

  task automatic wait_idle(input int budget);
    int guard;
    guard = 0;
    while (s_busy && guard < budget) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("idle_reached", s_busy, 1'b0);
  endtask

  task automatic wait_write(input logic [7:0] idx, input int budget);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #2;
      guard++;
    end while (!(s_oam_we && s_oam_addr == idx) && guard < budget);
    check("reach_write", {s_oam_we, s_oam_addr}, {1'b1, idx});
  endtask

  task automatic compare_all(input string tag, input logic [7:0] page, input int n);
    int nr, nw;
    nr = rd_q.size() - rd_base;
    nw = wr_q.size() - wr_base;
    check({tag, "_reads"}, nr, exp_rd.size());
    check({tag, "_writes"}, nw, exp_wr.size());
    for (int i = 0; i < exp_rd.size() && i < nr; i++) begin
      check($sformatf("%s_rd_addr%0d", tag, i), rd_q[rd_base + i], exp_rd[i]);
      check($sformatf("%s_rd_tick%0d", tag, i), rdt_q[rd_base + i], exp_dt[i]);
    end
    for (int i = 0; i < exp_wr.size() && i < nw; i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[wr_base + i], exp_wr[i]);
    check({tag, "_busy_ticks"}, busy_ticks, n + 1);
    check({tag, "_overlap"}, overlap - ov_base, 0);
    check({tag, "_dma_reg"}, s_dma_reg, page);
    check({tag, "_cpu_block_idle"}, s_cpu_block, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] page;
    bus_a.start = 1'b0; bus_a.start_page = 8'h00;
    bus_b.start = 1'b0; bus_b.start_page = 8'h00;

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    check("rst_src_re",    bus_a.src_re,    1'b0);
    check("rst_oam_we",    bus_a.oam_we,    1'b0);
    check("rst_busy",      bus_a.busy,      1'b0);
    check("rst_cpu_block", bus_a.cpu_block, 1'b0);
    check("rst_src_addr",  bus_a.src_addr,  16'h0000);
    check("rst_oam_addr",  bus_a.oam_addr,  8'h00);
    check("rst_oam_wdata", bus_a.oam_wdata, 8'h00);
    check("rst_dma_reg",   bus_a.dma_reg,   8'h00);
    check("rst_b_busy",    bus_b.busy,      1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Page C1, address-as-data, 4-clk machine cycle
    key = 8'h00; tick_period = 4;
    mark();
    add_expected(8'hC1, 160);
    do_start(1'b0, 8'hC1);
    check("c1_busy_next",      s_busy,      1'b1);
    check("c1_cpu_block_next", s_cpu_block, 1'b1);
    wait_idle(3000);
    compare_all("c1", 8'hC1, 160);

    // Echo page E2, start coincident with a tick, random spacing and data
    key = 8'($urandom); tick_period = 0;
    mark();
    add_expected(8'hE2, 160);
    do_start(1'b1, 8'hE2);
    check("e2_dma_reg_early", s_dma_reg, 8'hE2);
    wait_idle(3000);
    compare_all("e2", 8'hE2, 160);

    // Restart with page D0 during the write of byte 50
    key = 8'($urandom); tick_period = 3;
    page = 8'($urandom);
    mark();
    add_expected(page, 51);
    add_expected(8'hD0, 160);
    do_start(1'($urandom_range(0, 1)), page);
    wait_write(8'd50, 1000);
    pulse_start(8'hD0);
    check("rs_busy_held", s_busy, 1'b1);
    wait_idle(3000);
    compare_all("rs", 8'hD0, 160);

    // Reset during byte 80
    key = 8'($urandom); tick_period = 0;
    mark();
    do_start(1'b0, 8'($urandom));
    wait_write(8'd80, 1000);
    rst_n = 1'b0;
    #1;
    check("ar_oam_we",    s_oam_we,    1'b0);
    check("ar_src_re",    s_src_re,    1'b0);
    check("ar_busy",      s_busy,      1'b0);
    check("ar_cpu_block", s_cpu_block, 1'b0);
    check("ar_src_addr",  s_src_addr,  16'h0000);
    check("ar_oam_addr",  s_oam_addr,  8'h00);
    check("ar_oam_wdata", s_oam_wdata, 8'h00);
    check("ar_dma_reg",   s_dma_reg,   8'h00);
    mark();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    check("ar_no_writes", wr_q.size() - wr_base, 0);
    check("ar_no_reads",  rd_q.size() - rd_base, 0);
    check("ar_idle",      s_busy, 1'b0);
    check("ar_dma_reg_hold", s_dma_reg, 8'h00);

    // First start after reset: random page and spacing
    key = 8'($urandom); tick_period = 0;
    page = 8'($urandom);
    mark();
    add_expected(page, 160);
    do_start(1'($urandom_range(0, 1)), page);
    wait_idle(3000);
    compare_all("rnd", page, 160);

    // 4-byte instance with tick every 2 clk
    sel = 1'b1; key = 8'($urandom); tick_period = 2;
    page = 8'($urandom);
    repeat (4) @(posedge clk);
    mark();
    add_expected(page, 4);
    do_start(1'b0, page);
    wait_idle(100);
    compare_all("b4", page, 4);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
